core8_shared_onchip_memory: RTL and testbench



---
 rtl/core8_shared_onchip_memory_pkg.sv | 21 ++
 rtl/core8_shared_onchip_memory_if.sv | 29 ++
 rtl/core8_shared_onchip_memory_rr_arbiter.sv | 37 +++
 rtl/core8_shared_onchip_memory.sv | 159 +++++++++++++++
 tb/tb_core8_shared_onchip_memory.sv | 277 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/core8_shared_onchip_memory_pkg.sv
// Shared definitions for the Core8 shared on-chip memory: port limits,
// read latencies and the read-pipeline entry type.
package core8_shmem_pkg;

  localparam int unsigned SHMEM_MAX_PORTS  = 8;
  localparam int unsigned SHMEM_LAT_BASE   = 1;
  localparam int unsigned SHMEM_LAT_OUTREG = 2;
  localparam int unsigned SHMEM_IDX_W      = $clog2(SHMEM_MAX_PORTS);

  // One read-pipeline slot: which port the returning word belongs to.
  typedef struct packed {
    logic                   valid;
    logic [SHMEM_IDX_W-1:0] port_idx;
  } shmem_pipe_t;

  // Round-robin successor of port g among n ports.
  function automatic int unsigned shmem_rr_next(input int unsigned g, input int unsigned n);
    return (g + 1 >= n) ? 0 : g + 1;
  endfunction

endpackage

// File: rtl/core8_shared_onchip_memory_if.sv
// Flattened multi-port Avalon-MM bus for the Core8 shared memory.
// Port i occupies slice i of every vector.
interface core8_shared_onchip_memory_if #(
  parameter int unsigned NUM_PORTS = 2,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned ADDR_W    = 13
);

  logic [NUM_PORTS-1:0]          chipselect;
  logic [NUM_PORTS-1:0]          read;
  logic [NUM_PORTS-1:0]          write;
  logic [NUM_PORTS*ADDR_W-1:0]   address;
  logic [NUM_PORTS*DATA_W/8-1:0] byteenable;
  logic [NUM_PORTS*DATA_W-1:0]   writedata;
  logic [NUM_PORTS-1:0]          waitrequest;
  logic [NUM_PORTS*DATA_W-1:0]   readdata;
  logic [NUM_PORTS-1:0]          readdatavalid;

  modport master (
    output chipselect, read, write, address, byteenable, writedata,
    input  waitrequest, readdata, readdatavalid
  );

  modport slave (
    input  chipselect, read, write, address, byteenable, writedata,
    output waitrequest, readdata, readdatavalid
  );

endinterface

// File: rtl/core8_shared_onchip_memory_rr_arbiter.sv
// Combinational round-robin arbiter: the first requesting port at or after
// i_ptr wins, wrapping around; no grant when i_en is low.
module core8_shmem_rr_arbiter #(
  parameter int unsigned NUM_PORTS = 2,
  parameter int unsigned PTR_W     = $clog2(NUM_PORTS)
) (
  input  logic [NUM_PORTS-1:0] i_req,
  input  logic [PTR_W-1:0]     i_ptr,
  input  logic                 i_en,
  output logic [NUM_PORTS-1:0] o_grant,
  output logic [PTR_W-1:0]     o_grant_idx
);

  logic w_found;

  // Two passes (ports >= ptr, then ports < ptr) express the wrap-around search.
  always_comb begin
    o_grant     = '0;
    o_grant_idx = '0;
    w_found     = 1'b0;
    for (int unsigned p = 0; p < NUM_PORTS; p++) begin
      if (i_en && !w_found && i_req[p] && (p >= 32'(i_ptr))) begin
        o_grant[p]  = 1'b1;
        o_grant_idx = PTR_W'(p);
        w_found     = 1'b1;
      end
    end
    for (int unsigned p = 0; p < NUM_PORTS; p++) begin
      if (i_en && !w_found && i_req[p] && (p < 32'(i_ptr))) begin
        o_grant[p]  = 1'b1;
        o_grant_idx = PTR_W'(p);
        w_found     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/core8_shared_onchip_memory.sv
// Core8 shared on-chip memory: NUM_PORTS Avalon-MM slave ports arbitrated
// round-robin onto one single-port RAM, with pipelined per-port read return.
// Optional feature macro: CORE8_SHMEM_OUTREG_EN adds an output register stage
// (read latency 2 instead of 1).
module core8_shared_onchip_memory
  import core8_shmem_pkg::*;
#(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned ADDR_W    = 13,
  parameter int unsigned NUM_PORTS = 2,
  parameter string       INIT_FILE = ""
) (
  input logic clk,
  input logic reset_n,
  input logic clken,
  input logic reset_req,
  core8_shared_onchip_memory_if.slave bus
);

  localparam int unsigned BE_W  = DATA_W / 8;
  localparam int unsigned DEPTH = 2 ** ADDR_W;
  localparam int unsigned PTR_W = $clog2(NUM_PORTS);

  logic [NUM_PORTS-1:0]        w_active;
  logic [NUM_PORTS-1:0]        w_grant;
  logic [NUM_PORTS-1:0]        w_pipe_hit;
  logic [PTR_W-1:0]            w_gidx;
  logic [PTR_W-1:0]            r_rr_ptr;
  logic                        w_en;
  logic                        w_wr_sel;
  logic                        w_rd_sel;
  logic [ADDR_W-1:0]           w_addr;
  logic [BE_W-1:0]             w_be;
  logic [DATA_W-1:0]           w_wdata;
  logic [DATA_W-1:0]           r_ram_q;
  logic [DATA_W-1:0]           r_mem [0:DEPTH-1];
  shmem_pipe_t                 r_pipe;
  logic [NUM_PORTS*DATA_W-1:0] r_rdata;

  assign w_active = bus.chipselect & (bus.read | bus.write);
  assign w_en     = clken & ~reset_req;

  core8_shmem_rr_arbiter #(
    .NUM_PORTS (NUM_PORTS),
    .PTR_W     (PTR_W)
  ) u_arb (
    .i_req       (w_active),
    .i_ptr       (r_rr_ptr),
    .i_en        (w_en),
    .o_grant     (w_grant),
    .o_grant_idx (w_gidx)
  );

  assign bus.waitrequest = w_active & ~w_grant;

  // Route the granted port's request onto the RAM port; write beats read.
  always_comb begin
    w_addr   = '0;
    w_be     = '0;
    w_wdata  = '0;
    w_wr_sel = 1'b0;
    w_rd_sel = 1'b0;
    for (int unsigned p = 0; p < NUM_PORTS; p++) begin
      if (w_grant[p]) begin
        w_addr   = bus.address[p*ADDR_W +: ADDR_W];
        w_be     = bus.byteenable[p*BE_W +: BE_W];
        w_wdata  = bus.writedata[p*DATA_W +: DATA_W];
        w_wr_sel = bus.write[p];
        w_rd_sel = bus.read[p] & ~bus.write[p];
      end
    end
  end

  // Single-port RAM with byte-lane writes and registered read; contents are not reset.
  always_ff @(posedge clk) begin
    if (w_wr_sel) begin
      for (int unsigned b = 0; b < BE_W; b++) begin
        if (w_be[b]) begin
          r_mem[w_addr][b*8 +: 8] <= w_wdata[b*8 +: 8];
        end
      end
    end
    if (w_rd_sel) begin
      r_ram_q <= r_mem[w_addr];
    end
  end

  // Round-robin pointer moves past the port just granted.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rr_ptr <= '0;
    end else if (|w_grant) begin
      r_rr_ptr <= PTR_W'(shmem_rr_next(32'(w_gidx), NUM_PORTS));
    end
  end

  // Read pipeline tags each RAM read with its port; it runs regardless of clken.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pipe <= '0;
    end else begin
      r_pipe.valid    <= w_rd_sel;
      r_pipe.port_idx <= SHMEM_IDX_W'(w_gidx);
    end
  end

  // Decode which port the returning RAM word belongs to.
  always_comb begin
    w_pipe_hit = '0;
    for (int unsigned p = 0; p < NUM_PORTS; p++) begin
      w_pipe_hit[p] = r_pipe.valid && (r_pipe.port_idx == SHMEM_IDX_W'(p));
    end
  end

  // Per-port data register captures each returned word and holds it afterwards.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rdata <= '0;
    end else begin
      for (int unsigned p = 0; p < NUM_PORTS; p++) begin
        if (w_pipe_hit[p]) begin
          r_rdata[p*DATA_W +: DATA_W] <= r_ram_q;
        end
      end
    end
  end

`ifdef CORE8_SHMEM_OUTREG_EN
  logic [NUM_PORTS-1:0] r_rdv;

  // Output stage: valid is delayed to line up with the registered data.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rdv <= '0;
    end else begin
      r_rdv <= w_pipe_hit;
    end
  end

  assign bus.readdatavalid = r_rdv;
  assign bus.readdata      = r_rdata;
`else
  logic [NUM_PORTS*DATA_W-1:0] w_rdata;

  // Returning word bypasses the hold register so data and valid appear together.
  always_comb begin
    w_rdata = r_rdata;
    for (int unsigned p = 0; p < NUM_PORTS; p++) begin
      if (w_pipe_hit[p]) begin
        w_rdata[p*DATA_W +: DATA_W] = r_ram_q;
      end
    end
  end

  assign bus.readdatavalid = w_pipe_hit;
  assign bus.readdata      = w_rdata;
`endif

endmodule

// File: tb/tb_core8_shared_onchip_memory.sv
// Self-checking bench for core8_shared_onchip_memory (2-port main instance,
// plus a 4-port instance for rotation order).
module tb_core8_shared_onchip_memory;
  import core8_shmem_pkg::*;

  localparam int NP = 2;
  localparam int DW = 32;
  localparam int AW = 13;
`ifdef CORE8_SHMEM_OUTREG_EN
  localparam int LAT = SHMEM_LAT_OUTREG;
`else
  localparam int LAT = SHMEM_LAT_BASE;
`endif

  logic clk = 1'b0;
  logic reset_n, clken, reset_req;
  always #5 clk = ~clk;

  core8_shared_onchip_memory_if #(.NUM_PORTS(NP), .DATA_W(DW), .ADDR_W(AW)) bus ();
  core8_shared_onchip_memory_if #(.NUM_PORTS(4), .DATA_W(DW), .ADDR_W(4)) bus4 ();

  core8_shared_onchip_memory #(.DATA_W(DW), .ADDR_W(AW), .NUM_PORTS(NP), .INIT_FILE("")) dut (
    .clk(clk), .reset_n(reset_n), .clken(clken), .reset_req(reset_req), .bus(bus)
  );

  core8_shared_onchip_memory #(.DATA_W(DW), .ADDR_W(4), .NUM_PORTS(4), .INIT_FILE("")) dut4 (
    .clk(clk), .reset_n(reset_n), .clken(clken), .reset_req(reset_req), .bus(bus4)
  );

  // Bench-side request state per port
  logic [NP-1:0] cs, rd, wr;
  logic [AW-1:0] ad [NP];
  logic [3:0]    be [NP];
  logic [31:0]   wd [NP];

  always_comb begin
    bus.chipselect = cs;
    bus.read       = rd;
    bus.write      = wr;
    bus.address    = '0;
    bus.byteenable = '0;
    bus.writedata  = '0;
    for (int p = 0; p < NP; p++) begin
      bus.address[p*AW +: AW]    = ad[p];
      bus.byteenable[p*4 +: 4]   = be[p];
      bus.writedata[p*DW +: DW]  = wd[p];
    end
  end

  // Reference model state
  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  int ptr_m  = 0;
  logic [31:0]      mem_m [int];
  logic [NP*DW-1:0] hold_m;
  logic [NP-1:0]    keep_m;
  typedef struct {
    int          port;
    logic [31:0] data;
    int          due;
  } rd_t;
  rd_t pend [$];
  logic [AW-1:0] pool [8];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    cs = '0; rd = '0; wr = '0;
    for (int p = 0; p < NP; p++) begin
      ad[p] = '0; be[p] = '0; wd[p] = '0;
    end
  endtask

  task automatic setp(input int p, input logic c, input logic r, input logic w,
                      input logic [AW-1:0] a, input logic [3:0] b, input logic [31:0] d);
    cs[p] = c; rd[p] = r; wr[p] = w; ad[p] = a; be[p] = b; wd[p] = d;
  endtask

  task automatic model_clear();
    pend.delete();
    hold_m = '0;
    ptr_m  = 0;
    keep_m = '0;
  endtask

  // One bus cycle: check the DUT against the model, advance the model, clock.
  task automatic tick();
    logic [NP-1:0] act, gnt, rdv_m;
    int g;
    rd_t e;
    #1;
    act = cs & (rd | wr);
    gnt = '0;
    g   = -1;
    if (clken && !reset_req) begin
      for (int k = 0; k < NP; k++) begin
        int p;
        p = (ptr_m + k) % NP;
        if (g < 0 && act[p]) g = p;
      end
    end
    if (g >= 0) gnt[g] = 1'b1;
    chk("waitrequest", 64'(bus.waitrequest), 64'(act & ~gnt));
    rdv_m = '0;
    while (pend.size() > 0 && pend[0].due == cyc) begin
      rdv_m[pend[0].port] = 1'b1;
      hold_m[pend[0].port*DW +: DW] = pend[0].data;
      void'(pend.pop_front());
    end
    chk("readdatavalid", 64'(bus.readdatavalid), 64'(rdv_m));
    chk("readdata", 64'(bus.readdata), 64'(hold_m));
    keep_m = act & ~gnt;
    if (g >= 0) begin
      if (wr[g]) begin
        logic [31:0] v;
        v = mem_m.exists(int'(ad[g])) ? mem_m[int'(ad[g])] : 32'h0;
        for (int b = 0; b < 4; b++) if (be[g][b]) v[b*8 +: 8] = wd[g][b*8 +: 8];
        mem_m[int'(ad[g])] = v;
      end else begin
        e.port = g;
        e.data = mem_m.exists(int'(ad[g])) ? mem_m[int'(ad[g])] : 32'h0;
        e.due  = cyc + LAT;
        pend.push_back(e);
      end
      ptr_m = (g + 1) % NP;
    end
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    idle();
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit exceeded");
    $fatal(1, "timeout");
  end

  initial begin
    logic [3:0] exp4;
    reset_n = 1'b0; clken = 1'b1; reset_req = 1'b0;
    idle();
    model_clear();
    bus4.chipselect = '0; bus4.read = '0; bus4.write = '0;
    bus4.address = '0; bus4.byteenable = '0; bus4.writedata = '0;
    pool[0] = 13'h0000; pool[1] = 13'h0001; pool[2] = 13'h0555; pool[3] = 13'h0AAA;
    pool[4] = 13'h1FFE; pool[5] = 13'h1FFF; pool[6] = 13'h0010; pool[7] = 13'h0030;

    // Reset state
    do_reset();
    #1;
    chk("rst_rdv", 64'(bus.readdatavalid), 64'h0);
    chk("rst_rdata", 64'(bus.readdata), 64'h0);
    chk("rst_waitreq", 64'(bus.waitrequest), 64'h0);
    @(posedge clk); cyc++; #1;

    // 4-port full contention: grants rotate 0,1,2,3,0
    bus4.chipselect = 4'hF; bus4.read = 4'hF;
    for (int k = 0; k < 5; k++) begin
      #1;
      exp4 = 4'hF & ~(4'b0001 << (k % 4));
      chk("rr4_waitreq", 64'(bus4.waitrequest), 64'(exp4));
      @(posedge clk); cyc++; #1;
    end
    bus4.chipselect = '0; bus4.read = '0;

    // Basic write then read on the other port
    setp(0, 1, 0, 1, 13'h010, 4'hF, 32'hDEADBEEF); tick();
    idle(); setp(1, 1, 1, 0, 13'h010, 4'h0, 32'h0); tick();
    idle(); repeat (LAT + 1) tick();
    chk("basic_rdata", 64'(bus.readdata[63:32]), 64'(32'hDEADBEEF));

    // Byte enables
    setp(0, 1, 0, 1, 13'h030, 4'hF, 32'h11223344); tick();
    setp(0, 1, 0, 1, 13'h030, 4'h2, 32'h0000AA00); tick();
    idle(); setp(1, 1, 1, 0, 13'h030, 4'h0, 32'h0); tick();
    idle(); repeat (LAT + 1) tick();
    chk("be_rdata", 64'(bus.readdata[63:32]), 64'(32'h1122AA44));

    // Two-port contention straight after reset
    do_reset();
    setp(0, 1, 1, 0, 13'h010, 4'h0, 32'h0);
    setp(1, 1, 1, 0, 13'h030, 4'h0, 32'h0);
    repeat (6) tick();
    idle(); repeat (LAT + 1) tick();
    chk("cont_rdata", 64'(bus.readdata), {32'h1122AA44, 32'hDEADBEEF});

    // reset_req hold-off on a write
    setp(0, 1, 0, 1, 13'h020, 4'hF, 32'h12345678); tick();
    idle();
    reset_req = 1'b1;
    setp(0, 1, 0, 1, 13'h020, 4'hF, 32'h00000055);
    repeat (3) tick();
    reset_req = 1'b0; tick();
    idle(); setp(1, 1, 1, 0, 13'h020, 4'h0, 32'h0); tick();
    idle(); repeat (LAT + 1) tick();
    chk("stall_rr_rdata", 64'(bus.readdata[63:32]), 64'(32'h00000055));

    // clken stall: a stalled read released first still sees old contents
    setp(0, 1, 0, 1, 13'h020, 4'hF, 32'h12345678); tick();
    clken = 1'b0;
    setp(0, 1, 0, 1, 13'h020, 4'hF, 32'h00000066);
    setp(1, 1, 1, 0, 13'h020, 4'h0, 32'h0);
    repeat (3) tick();
    clken = 1'b1; tick();
    setp(1, 0, 0, 0, 13'h000, 4'h0, 32'h0); tick();
    idle(); repeat (LAT + 1) tick();
    chk("stall_ck_old", 64'(bus.readdata[63:32]), 64'(32'h12345678));
    setp(1, 1, 1, 0, 13'h020, 4'h0, 32'h0); tick();
    idle(); repeat (LAT + 1) tick();
    chk("stall_ck_new", 64'(bus.readdata[63:32]), 64'(32'h00000066));

    // Reset mid-read
    setp(1, 1, 1, 0, 13'h010, 4'h0, 32'h0); tick();
    reset_n = 1'b0;
    idle();
    model_clear();
    #1;
    chk("midrst_rdv", 64'(bus.readdatavalid), 64'h0);
    chk("midrst_rdata", 64'(bus.readdata), 64'h0);
    repeat (2) @(posedge clk);
    cyc += 2;
    #1;
    reset_n = 1'b1;
    repeat (LAT + 2) tick();
    setp(0, 1, 1, 0, 13'h010, 4'h0, 32'h0);
    setp(1, 1, 1, 0, 13'h030, 4'h0, 32'h0);
    #1;
    chk("midrst_ptr", 64'(bus.waitrequest), 64'(2'b10));
    tick(); tick();
    idle(); repeat (LAT + 1) tick();

    // Top address boundary
    setp(1, 1, 0, 1, 13'h1FFF, 4'hF, 32'hA5A55A5A); tick();
    idle(); setp(0, 1, 1, 0, 13'h1FFF, 4'h0, 32'h0); tick();
    idle(); repeat (LAT + 1) tick();
    chk("boundary_rdata", 64'(bus.readdata[31:0]), 64'(32'hA5A55A5A));

    // Randomized traffic over a pre-written address pool
    for (int i = 0; i < 8; i++) begin
      setp(0, 1, 0, 1, pool[i], 4'hF, $urandom); tick();
    end
    idle();
    for (int i = 0; i < 300; i++) begin
      clken     = ($urandom_range(0, 9) != 0);
      reset_req = ($urandom_range(0, 9) == 0);
      for (int p = 0; p < NP; p++) begin
        if (!keep_m[p]) begin
          setp(p, 1'($urandom), 1'($urandom), 1'($urandom), pool[$urandom_range(0, 7)],
               4'($urandom), $urandom);
        end
      end
      tick();
    end
    clken = 1'b1; reset_req = 1'b0;
    idle(); repeat (LAT + 2) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
